// File: rtl/cpu_bus_memory_responder.sv
// Memory-side target for the control unit's read/write/enable bus.
// Serves byte requests from internal RAM or the fixed vector block, inserts
// WAIT_STATES wait cycles after accept, and answers with a one-cycle ack.
// Timing: a request sampled on edge N is acked in the cycle after edge
// N+1+WAIT_STATES. Ack, rdata, busy and bus_error all come straight from flops.

module cpu_bus_memory_responder #(
    parameter int unsigned RAM_AW      = 11,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [15:0] NMI_VEC     = 16'h0000,
    parameter logic [15:0] RST_VEC     = 16'h0200,
    parameter logic [15:0] IRQ_VEC     = 16'h0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pcl,
    input  logic [7:0] pch,
    input  logic       read,
    input  logic       write,
    input  logic       enable,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ack,
    output logic       busy,
    output logic       bus_error
);

    // Reject configurations the 4-bit wait counter or 16-bit map cannot express.
    generate
        if (WAIT_STATES > 15) begin : g_bad_wait_states
            $error("WAIT_STATES must be in the range 0..15");
        end
        if (RAM_AW < 1 || RAM_AW > 16) begin : g_bad_ram_aw
            $error("RAM_AW must be in the range 1..16");
        end
    endgenerate

    localparam int unsigned RamDepth = 1 << RAM_AW;
    // Counter preload; the zero-wait case never enters the wait state.
    localparam logic [3:0]  WaitLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        op_wr_q, op_wr_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        bus_error_q, bus_error_d;

    logic [7:0]  mem_q [RamDepth];

    logic        req_valid;
    logic        req_conflict;
    logic        ram_hit;
    logic        vec_hit;
    logic [7:0]  vec_byte;
    logic [7:0]  read_byte;
    logic        commit_en;

    // Address bits above RAM_AW are fully decoded so the RAM never aliases.
    function automatic logic is_ram(input logic [15:0] a);
        return (a >> RAM_AW) == 16'd0;
    endfunction

    assign req_valid    = enable & (read ^ write);
    assign req_conflict = enable & read & write;

    // Decode of the latched address, used while responding.
    always_comb begin
        ram_hit = is_ram(addr_q);
        vec_hit = (addr_q >= 16'hFFFA);
        unique case (addr_q[2:0])
            3'b010:  vec_byte = NMI_VEC[7:0];
            3'b011:  vec_byte = NMI_VEC[15:8];
            3'b100:  vec_byte = RST_VEC[7:0];
            3'b101:  vec_byte = RST_VEC[15:8];
            3'b110:  vec_byte = IRQ_VEC[7:0];
            3'b111:  vec_byte = IRQ_VEC[15:8];
            default: vec_byte = 8'hFF;
        endcase
        if (ram_hit) begin
            read_byte = mem_q[addr_q[RAM_AW-1:0]];
        end else if (vec_hit) begin
            read_byte = vec_byte;
        end else begin
            read_byte = 8'hFF;
        end
    end

    // Next-state logic for the request FSM and its registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        op_wr_d     = op_wr_q;
        rdata_d     = rdata_q;
        ack_d       = 1'b0;
        bus_error_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = {pch, pcl};
                    wdata_d = wdata;
                    op_wr_d = write;
                    cnt_d   = WaitLoad;
                    state_d = (WAIT_STATES == 0) ? StResp : StWait;
                end else if (req_conflict) begin
                    bus_error_d = 1'b1;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                ack_d   = 1'b1;
                state_d = StIdle;
                if (!op_wr_q) begin
                    rdata_d = read_byte;
                end
                // Unmapped accesses and vector writes complete but are flagged.
                bus_error_d = !ram_hit && (op_wr_q || !vec_hit);
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Busy covers accept through the ack cycle inclusive.
        busy_d = (state_d != StIdle) || ack_d;
    end

    // A write lands on the edge that enters the response state; reset discards it.
    assign commit_en = !reset && (state_d == StResp) && op_wr_d && is_ram(addr_d);

    // FSM state, latched request and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            op_wr_q     <= 1'b0;
            rdata_q     <= 8'h00;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            op_wr_q     <= op_wr_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            bus_error_q <= bus_error_d;
        end
    end

    // RAM array; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit_en) begin
            mem_q[addr_d[RAM_AW-1:0]] <= wdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign bus_error = bus_error_q;

endmodule

// File: tb/tb_cpu_bus_memory_responder.sv
// Directed bench: three responders (WAIT_STATES 1, 0, 3) with private request
// inputs and a shared clock/reset; each task drives one scenario and checks it.

module tb_cpu_bus_memory_responder;

    logic clk = 1'b0;
    logic reset;

    logic [2:0][7:0] pcl_s, pch_s, wdata_s, rdata_s;
    logic [2:0]      read_s, write_s, enable_s, ack_s, busy_s, berr_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_bus_memory_responder #(.WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(reset), .pcl(pcl_s[0]), .pch(pch_s[0]), .read(read_s[0]),
        .write(write_s[0]), .enable(enable_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]),
        .ack(ack_s[0]), .busy(busy_s[0]), .bus_error(berr_s[0])
    );

    cpu_bus_memory_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .pcl(pcl_s[1]), .pch(pch_s[1]), .read(read_s[1]),
        .write(write_s[1]), .enable(enable_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]),
        .ack(ack_s[1]), .busy(busy_s[1]), .bus_error(berr_s[1])
    );

    cpu_bus_memory_responder #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(reset), .pcl(pcl_s[2]), .pch(pch_s[2]), .read(read_s[2]),
        .write(write_s[2]), .enable(enable_s[2]), .wdata(wdata_s[2]), .rdata(rdata_s[2]),
        .ack(ack_s[2]), .busy(busy_s[2]), .bus_error(berr_s[2])
    );

    // One request on responder d; returns the ack-cycle data/error and latency
    // (k where ack is seen in the cycle after accept edge + k; 20 means no ack).
    task automatic xfer(input int d, input logic wr, input logic [15:0] a,
                        input logic [7:0] wd, output logic [7:0] rd, output logic err,
                        output int lat);
        @(negedge clk);
        pch_s[d] = a[15:8]; pcl_s[d] = a[7:0]; wdata_s[d] = wd;
        read_s[d] = ~wr; write_s[d] = wr; enable_s[d] = 1'b1;
        @(negedge clk);
        enable_s[d] = 1'b0; read_s[d] = 1'b0; write_s[d] = 1'b0;
        lat = 0;
        while (ack_s[d] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd  = rdata_s[d];
        err = berr_s[d];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pcl_s = '0; pch_s = '0; wdata_s = '0;
        read_s = '0; write_s = '0; enable_s = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (rdata_s[d] !== 8'h00) begin
                n_fail++; $display("FAIL reset_rdata[%0d] got %h want 00", d, rdata_s[d]);
            end
            n_checks++;
            if (ack_s[d] !== 1'b0) begin
                n_fail++; $display("FAIL reset_ack[%0d] got %b want 0", d, ack_s[d]);
            end
            n_checks++;
            if (busy_s[d] !== 1'b0) begin
                n_fail++; $display("FAIL reset_busy[%0d] got %b want 0", d, busy_s[d]);
            end
            n_checks++;
            if (berr_s[d] !== 1'b0) begin
                n_fail++; $display("FAIL reset_berr[%0d] got %b want 0", d, berr_s[d]);
            end
        end
    endtask

    task automatic test_ram_rw();
        logic [7:0] rd; logic err; int lat;
        xfer(0, 1'b1, 16'h0010, 8'hA5, rd, err, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL wr_latency got %0d want 2", lat); end
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL wr_berr got %b want 0", err); end
        xfer(0, 1'b0, 16'h0010, 8'h00, rd, err, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL rd_latency got %0d want 2", lat); end
        n_checks++;
        if (rd !== 8'hA5) begin n_fail++; $display("FAIL rd_0010 got %h want a5", rd); end
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL rd_berr got %b want 0", err); end
        // Top RAM byte and byte 0 for the unmapped scenario.
        xfer(0, 1'b1, 16'h07FF, 8'hC3, rd, err, lat);
        xfer(0, 1'b1, 16'h0000, 8'h5A, rd, err, lat);
        xfer(0, 1'b0, 16'h07FF, 8'h00, rd, err, lat);
        n_checks++;
        if (rd !== 8'hC3 || err !== 1'b0) begin
            n_fail++; $display("FAIL rd_07ff got %h/%b want c3/0", rd, err);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] rd; logic err; int lat;
        xfer(0, 1'b0, 16'hFFFC, 8'h00, rd, err, lat);
        n_checks++;
        if (rd !== 8'h00 || err !== 1'b0) begin
            n_fail++; $display("FAIL vec_fffc got %h/%b want 00/0", rd, err);
        end
        xfer(0, 1'b0, 16'hFFFD, 8'h00, rd, err, lat);
        n_checks++;
        if (rd !== 8'h02 || err !== 1'b0) begin
            n_fail++; $display("FAIL vec_fffd got %h/%b want 02/0", rd, err);
        end
        xfer(0, 1'b1, 16'hFFFC, 8'h55, rd, err, lat);
        n_checks++;
        if (lat !== 2 || err !== 1'b1) begin
            n_fail++; $display("FAIL vec_write got lat %0d err %b want 2/1", lat, err);
        end
        @(negedge clk);
        n_checks++;
        if (berr_s[0] !== 1'b0) begin
            n_fail++; $display("FAIL vec_berr_pulse got %b want 0", berr_s[0]);
        end
        xfer(0, 1'b0, 16'hFFFC, 8'h00, rd, err, lat);
        n_checks++;
        if (rd !== 8'h00 || err !== 1'b0) begin
            n_fail++; $display("FAIL vec_reread got %h/%b want 00/0", rd, err);
        end
    endtask

    task automatic test_unmapped();
        logic [7:0] rd; logic err; int lat;
        xfer(0, 1'b0, 16'h8000, 8'h00, rd, err, lat);
        n_checks++;
        if (rd !== 8'hFF || err !== 1'b1 || lat !== 2) begin
            n_fail++; $display("FAIL unm_rd_8000 got %h/%b/%0d want ff/1/2", rd, err, lat);
        end
        xfer(0, 1'b0, 16'h0800, 8'h00, rd, err, lat);
        n_checks++;
        if (rd !== 8'hFF || err !== 1'b1) begin
            n_fail++; $display("FAIL unm_rd_0800 got %h/%b want ff/1", rd, err);
        end
        xfer(0, 1'b1, 16'h8000, 8'h77, rd, err, lat);
        n_checks++;
        if (err !== 1'b1 || lat !== 2) begin
            n_fail++; $display("FAIL unm_wr got err %b lat %0d want 1/2", err, lat);
        end
        xfer(0, 1'b0, 16'h0000, 8'h00, rd, err, lat);
        n_checks++;
        if (rd !== 8'h5A || err !== 1'b0) begin
            n_fail++; $display("FAIL unm_ram0 got %h/%b want 5a/0", rd, err);
        end
    endtask

    task automatic test_conflict();
        logic [7:0] rd; logic err; int lat;
        logic saw_ack, saw_busy, saw_berr;
        @(negedge clk);
        pch_s[0] = 8'h00; pcl_s[0] = 8'h10;
        read_s[0] = 1'b1; write_s[0] = 1'b1; enable_s[0] = 1'b1;
        @(negedge clk);
        enable_s[0] = 1'b0; read_s[0] = 1'b0; write_s[0] = 1'b0;
        n_checks++;
        if (berr_s[0] !== 1'b1 || ack_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_pulse got berr %b ack %b busy %b want 1/0/0",
                     berr_s[0], ack_s[0], busy_s[0]);
        end
        saw_ack = 1'b0; saw_busy = 1'b0; saw_berr = 1'b0;
        repeat (4) begin
            @(negedge clk);
            saw_ack  |= ack_s[0];
            saw_busy |= busy_s[0];
            saw_berr |= berr_s[0];
        end
        n_checks++;
        if (saw_ack !== 1'b0 || saw_busy !== 1'b0 || saw_berr !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_after got ack %b busy %b berr %b want 0/0/0",
                     saw_ack, saw_busy, saw_berr);
        end
        xfer(0, 1'b0, 16'h0010, 8'h00, rd, err, lat);
        n_checks++;
        if (rd !== 8'hA5 || err !== 1'b0 || lat !== 2) begin
            n_fail++; $display("FAIL conflict_next_rd got %h/%b/%0d want a5/0/2", rd, err, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd; logic err; int lat;
        xfer(1, 1'b1, 16'h0001, 8'h11, rd, err, lat);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL ws0_latency got %0d want 1", lat); end
        xfer(1, 1'b1, 16'h0002, 8'h22, rd, err, lat);
        xfer(1, 1'b1, 16'h0003, 8'h33, rd, err, lat);
        @(negedge clk);
        pch_s[1] = 8'h00; pcl_s[1] = 8'h01; read_s[1] = 1'b1; write_s[1] = 1'b0;
        enable_s[1] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy_s[1] !== 1'b1 || ack_s[1] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_busy got busy %b ack %b want 1/0", busy_s[1], ack_s[1]);
        end
        // A write offered while busy must be ignored.
        pcl_s[1] = 8'h03; wdata_s[1] = 8'hEE; read_s[1] = 1'b0; write_s[1] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ack_s[1] !== 1'b1 || rdata_s[1] !== 8'h11) begin
            n_fail++; $display("FAIL b2b_ack1 got ack %b data %h want 1/11", ack_s[1], rdata_s[1]);
        end
        pcl_s[1] = 8'h02; read_s[1] = 1'b1; write_s[1] = 1'b0;
        @(negedge clk);
        enable_s[1] = 1'b0; read_s[1] = 1'b0;
        n_checks++;
        if (ack_s[1] !== 1'b0 || busy_s[1] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_gap got ack %b busy %b want 0/1", ack_s[1], busy_s[1]);
        end
        @(negedge clk);
        n_checks++;
        if (ack_s[1] !== 1'b1 || rdata_s[1] !== 8'h22 || berr_s[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ack2 got ack %b data %h berr %b want 1/22/0",
                     ack_s[1], rdata_s[1], berr_s[1]);
        end
        @(negedge clk);
        n_checks++;
        if (ack_s[1] !== 1'b0 || busy_s[1] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle got ack %b busy %b want 0/0", ack_s[1], busy_s[1]);
        end
        xfer(1, 1'b0, 16'h0003, 8'h00, rd, err, lat);
        n_checks++;
        if (rd !== 8'h33) begin n_fail++; $display("FAIL b2b_ignored_wr got %h want 33", rd); end
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] rd; logic err; int lat;
        logic saw_ack;
        xfer(2, 1'b1, 16'h0020, 8'h11, rd, err, lat);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL ws3_latency got %0d want 4", lat); end
        @(negedge clk);
        pch_s[2] = 8'h00; pcl_s[2] = 8'h20; wdata_s[2] = 8'h3C;
        read_s[2] = 1'b0; write_s[2] = 1'b1; enable_s[2] = 1'b1;
        @(negedge clk);
        enable_s[2] = 1'b0; write_s[2] = 1'b0;
        n_checks++;
        if (busy_s[2] !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_busy got %b want 1", busy_s[2]);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (busy_s[2] !== 1'b0 || ack_s[2] !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_drop got busy %b ack %b want 0/0", busy_s[2], ack_s[2]);
        end
        saw_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_ack |= ack_s[2];
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            saw_ack |= ack_s[2];
        end
        n_checks++;
        if (saw_ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_noack got %b want 0", saw_ack); end
        xfer(2, 1'b0, 16'h0020, 8'h00, rd, err, lat);
        n_checks++;
        if (rd !== 8'h11 || lat !== 4) begin
            n_fail++; $display("FAIL rst_mid_ram got %h/%0d want 11/4", rd, lat);
        end
    endtask

    initial begin
        test_reset();
        test_ram_rw();
        test_vectors();
        test_unmapped();
        test_conflict();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
